// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out UART-style transmitter.
// Ports: clk, reset_n (sync, active-low), in_data/in_valid/in_ready
//        (word handshake), tx (registered line, idle high), busy, tx_done.
//
// Frame on tx: start(0), DATA_BITS data bits LSB first, optional even
// parity bit, stop(1). Each line bit is held for CLKS_PER_BIT cycles.
// tx_done is high during the final cycle of the stop bit.

module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  BIT_LAST = 5'(DATA_BITS - 1);

    state_t               state;
    state_t               state_n;
    logic [15:0]          cnt;
    logic [15:0]          cnt_n;
    logic [4:0]           bitc;
    logic [4:0]           bitc_n;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] sh_n;
    logic [DATA_BITS-1:0] shifted;
    logic                 par;
    logic                 par_n;
    logic                 tx_n;
    logic                 last;

    // last cycle of the current line bit
    assign last     = (cnt == CNT_LAST);

    assign in_ready = reset_n && (state == IDLE);
    assign busy     = (state != IDLE);
    assign tx_done  = (state == STOP) && last;

    // State register; tx is a flop so the line never sees a
    // combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            bitc  <= '0;
            sh    <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitc  <= bitc_n;
            sh    <= sh_n;
            par   <= par_n;
            tx    <= tx_n;
        end
    end

    // Next-state logic. tx_n is the value the line takes after the
    // edge, so it is chosen from the state being entered.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitc_n  = bitc;
        sh_n    = sh;
        par_n   = par;
        tx_n    = tx;
        shifted = sh >> 1;

        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (in_valid && in_ready) begin
                    state_n = START;
                    sh_n    = in_data;
                    par_n   = ^in_data;
                    cnt_n   = '0;
                    bitc_n  = '0;
                    tx_n    = 1'b0;
                end
            end

            START: begin
                if (last) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bitc_n  = '0;
                    tx_n    = sh[0];
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            DATA: begin
                if (last) begin
                    cnt_n = '0;
                    sh_n  = shifted;
                    if (bitc == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bitc_n = bitc + 5'd1;
                        tx_n   = shifted[0];
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            PARITY: begin
                if (last) begin
                    state_n = STOP;
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            STOP: begin
                if (last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed checks of serial_tx in three configurations
// (defaults, even parity, one cycle per bit with 4 data bits).

module tb_serial_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_tx, a_busy, a_done;

    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_tx, b_busy, b_done;

    logic [3:0] c_data = '0;
    logic       c_valid = 1'b0;
    logic       c_ready, c_tx, c_busy, c_done;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    serial_tx u_a (
        .clk(clk), .reset_n(rst_n),
        .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .tx(a_tx), .busy(a_busy), .tx_done(a_done)
    );

    serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1)) u_b (
        .clk(clk), .reset_n(rst_n),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .tx(b_tx), .busy(b_busy), .tx_done(b_done)
    );

    serial_tx #(.CLKS_PER_BIT(1), .DATA_BITS(4), .PARITY_EN(0)) u_c (
        .clk(clk), .reset_n(rst_n),
        .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .tx(c_tx), .busy(c_busy), .tx_done(c_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level in cycle i (1-based) after the accept edge.
    function automatic logic expbit(input int i, input logic [15:0] data,
                                    input int nb, input int cpb,
                                    input int pe);
        int k;
        k = (i - 1) / cpb;
        if (k == 0) return 1'b0;
        if (k <= nb) return data[k-1];
        if (pe != 0 && k == nb + 1) return ^data;
        return 1'b1;
    endfunction

    function automatic logic obs_tx(input int d);
        case (d)
            0: return a_tx;
            1: return b_tx;
            default: return c_tx;
        endcase
    endfunction

    function automatic logic obs_done(input int d);
        case (d)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic obs_busy(input int d);
        case (d)
            0: return a_busy;
            1: return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic obs_ready(input int d);
        case (d)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    task automatic set_in(input int d, input logic [15:0] data,
                          input logic v);
        case (d)
            0: begin a_data = data[7:0]; a_valid = v; end
            1: begin b_data = data[7:0]; b_valid = v; end
            default: begin c_data = data[3:0]; c_valid = v; end
        endcase
    endtask

    // Offer `data`, accept on next edge, then replace in_data with `alt`
    // (valid kept high if keep=1) and check every cycle of the frame.
    task automatic frame(input int d, input logic [15:0] data,
                         input logic [15:0] alt, input logic keep);
        int nb, cpb, pe, len;
        nb  = (d == 2) ? 4 : 8;
        cpb = (d == 2) ? 1 : 4;
        pe  = (d == 1) ? 1 : 0;
        len = (2 + nb + pe) * cpb;
        set_in(d, data, 1'b1);
        tick;
        set_in(d, alt, keep);
        for (int i = 1; i <= len; i++) begin
            chk($sformatf("d%0d_%0h_tx[%0d]", d, data, i),
                16'(obs_tx(d)), 16'(expbit(i, data, nb, cpb, pe)));
            chk($sformatf("d%0d_%0h_done[%0d]", d, data, i),
                16'(obs_done(d)), 16'(i == len));
            chk($sformatf("d%0d_%0h_busy[%0d]", d, data, i),
                16'(obs_busy(d)), 16'd1);
            tick;
        end
        chk($sformatf("d%0d_%0h_ready_end", d, data),
            16'(obs_ready(d)), 16'd1);
        chk($sformatf("d%0d_%0h_idle_tx", d, data),
            16'(obs_tx(d)), 16'd1);
        chk($sformatf("d%0d_%0h_idle_busy", d, data),
            16'(obs_busy(d)), 16'd0);
    endtask

    initial begin
        // reset state
        tick;
        tick;
        chk("rst_tx", 16'(a_tx), 16'd1);
        chk("rst_busy", 16'(a_busy), 16'd0);
        chk("rst_done", 16'(a_done), 16'd0);
        chk("rst_ready", 16'(a_ready), 16'd0);
        chk("rst_ready_c", 16'(c_ready), 16'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 16'(a_ready), 16'd1);
        chk("rel_ready_b", 16'(b_ready), 16'd1);

        // basic frame, default configuration
        frame(0, 16'hA5, 16'hA5, 1'b0);

        // in_data changed after accept must not matter
        frame(0, 16'hFF, 16'h00, 1'b0);

        // back-to-back with in_valid held high: one idle cycle between
        frame(0, 16'h00, 16'hFF, 1'b1);
        frame(0, 16'hFF, 16'h00, 1'b0);

        // reset in cycle 15 of a 0x55 frame
        set_in(0, 16'h55, 1'b1);
        tick;
        set_in(0, 16'h55, 1'b0);
        for (int i = 1; i <= 14; i++) tick;
        chk("abort_pre_tx", 16'(a_tx), 16'(expbit(15, 16'h55, 8, 4, 0)));
        rst_n = 1'b0;
        tick;
        chk("abort_tx", 16'(a_tx), 16'd1);
        chk("abort_busy", 16'(a_busy), 16'd0);
        chk("abort_done", 16'(a_done), 16'd0);
        chk("abort_ready_low", 16'(a_ready), 16'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 16'(a_ready), 16'd1);
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("no_resume_tx[%0d]", i), 16'(a_tx), 16'd1);
            chk($sformatf("no_resume_done[%0d]", i), 16'(a_done), 16'd0);
            chk($sformatf("no_resume_busy[%0d]", i), 16'(a_busy), 16'd0);
            tick;
        end
        frame(0, 16'h3C, 16'h3C, 1'b0);

        // even parity: 0x07 -> parity 1, 0x03 -> parity 0, 44 cycles
        frame(1, 16'h07, 16'h07, 1'b0);
        frame(1, 16'h03, 16'h03, 1'b0);

        // one cycle per bit, 4 data bits: 0,1,0,0,1,1
        frame(2, 16'h9, 16'h9, 1'b0);
        frame(2, 16'h6, 16'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held on tx, legal range 1..65535.
REQ-002 The module SHALL have parameter DATA_BITS, default 8: payload bits per frame, legal range 1..16.
REQ-003 The module SHALL have parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_data, input, DATA_BITS bits: parallel word to transmit.
REQ-007 Port in_valid, input, 1 bit: in_data holds a word offered for transmission.
REQ-008 Port in_ready, output, 1 bit: transmitter accepts a word this cycle.
REQ-009 Port tx, output, 1 bit: serial line, idle high, registered.
REQ-010 Port busy, output, 1 bit: a frame is in progress (any state other than IDLE).
REQ-011 Port tx_done, output, 1 bit: one-cycle pulse marking the end of a frame.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP; PARITY is entered only when PARITY_EN=1.
REQ-013 in_ready SHALL equal 1 exactly when state is IDLE and reset_n=1.
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_data is latched into an internal shift register on that edge.
REQ-015 Changes to in_data after the accept edge SHALL have no effect on the frame in progress.
REQ-016 On accept, the FSM SHALL enter START; tx=0 from the accept edge onward.
REQ-017 A bit counter SHALL hold each line bit for exactly CLKS_PER_BIT cycles before advancing.
REQ-018 DATA SHALL transmit LSB first, one bit per CLKS_PER_BIT period, for DATA_BITS periods.
REQ-019 PARITY SHALL drive the XOR of all latched data bits, making the total count of ones across data plus parity even.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-021 tx_done SHALL be 1 during the last cycle of STOP only.
REQ-022 The FSM SHALL return to IDLE on the edge ending STOP.
REQ-023 Frame length SHALL be (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles from the accept edge to the IDLE-entry edge.
REQ-024 Back-to-back frames SHALL have a minimum of 1 IDLE cycle (tx=1) between frames; there is no accept during STOP.
REQ-025 in_valid SHALL be ignored when in_ready=0; no word is queued.
REQ-026 With CLKS_PER_BIT=1, every state SHALL last exactly one cycle per bit, with no skipped or doubled bits.
REQ-027 tx SHALL be glitch-free: driven from a flop, with no combinational path from inputs.

Reset
REQ-028 On a rising edge with reset_n=0, the block SHALL set state=IDLE, tx=1, busy=0, tx_done=0, and clear the bit counter, shift register and cycle counter.
REQ-029 in_ready SHALL be 0 while reset_n=0; no accept SHALL occur during reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame: tx=1 after the next edge, no tx_done pulse, and no resumption after release.
REQ-031 After reset_n returns to 1, in_ready SHALL read 1 in the same cycle (state already IDLE).

Verification
REQ-032 With defaults, reset, then in_data=0xA5 accepted at cycle T: tx reads 0 for T+1..T+4, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; tx_done=1 at T+40 only; in_ready=1 again at T+41.
REQ-033 With PARITY_EN=1 and in_data=0x07: parity bit=1, frame is 44 cycles; with in_data=0x03, parity bit=0.
REQ-034 in_valid held high with 0x00 then 0xFF on consecutive frames: each frame is separated by exactly 1 IDLE cycle; received bytes are 0x00 then 0xFF; exactly two tx_done pulses.
REQ-035 reset_n driven 0 at cycle 15 of a 0x55 frame for 1 cycle: tx=1, busy=0 next cycle, no tx_done, in_ready=1 after release, and a new 0x3C frame then transmits correctly.
REQ-036 CLKS_PER_BIT=1, DATA_BITS=4, in_data=0x9: tx sequence 0,1,0,0,1,1; tx_done on cycle 6.
REQ-037 in_data changed to 0x00 one cycle after accepting 0xFF: transmitted payload remains 0xFF.
